// File: rtl/wb_gpio_irq_pkg.sv
// wb_gpio_irq shared definitions: register map, cycle type,
// byte-lane helper.
package wb_gpio_irq_pkg;

    localparam logic [2:0] ADR_IN   = 3'd0;
    localparam logic [2:0] ADR_OUT  = 3'd1;
    localparam logic [2:0] ADR_DIR  = 3'd2;
    localparam logic [2:0] ADR_EN   = 3'd3;
    localparam logic [2:0] ADR_TYPE = 3'd4;
    localparam logic [2:0] ADR_POL  = 3'd5;
    localparam logic [2:0] ADR_STAT = 3'd6;
    localparam logic [2:0] ADR_RSVD = 3'd7;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone classic bus bundle for the gpio slave.
// Signal names follow the slave's point of view.
interface wb_gpio_irq_if;

    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        output wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
        input  wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/wb_gpio_irq_bit.sv
// One gpio line: synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// edge history, event decode and sticky status bit.
module gpio_irq_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
`ifdef GPIO_DEBOUNCE_EN
    input  logic tick,
`endif
    input  logic pad,
    input  logic en,
    input  logic typ,
    input  logic pol,
    input  logic clr,
    output logic in_o,
    output logic stat_o
);

    logic [SYNC_STAGES-1:0] sync;
    logic s_in;
    logic deb;
    logic prev;
    logic ev;

    assign s_in = sync[SYNC_STAGES-1];

    // shift the asynchronous pad through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], pad};
    end

`ifdef GPIO_DEBOUNCE_EN
    logic samp;

    // accept a new level only when two tick samples agree
    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= 1'b0;
            deb  <= 1'b0;
        end else if (tick) begin
            samp <= s_in;
            if (samp == s_in) deb <= s_in;
        end
    end
`else
    assign deb = s_in;
`endif

    // edge history tracks always so enabling never sees a stale edge
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= deb;
    end

    always_comb begin
        ev = (deb == pol);
        if (typ) ev = pol ? (deb & ~prev) : (~deb & prev);
    end

    // sticky status: a new event wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) stat_o <= 1'b0;
        else     stat_o <= (stat_o & ~clr) | (ev & en);
    end

    assign in_o = deb;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone gpio bank with per-bit interrupts.
// Optional input debounce selected by GPIO_DEBOUNCE_EN.
module wb_gpio_irq
    import wb_gpio_irq_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_DIV = 1000
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    wb_gpio_irq_if.slave     bus,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    logic             req;
    logic             rsvd;
    logic             wr;
    logic             ack_q;
    logic             err_q;
    logic             irq_q;
    logic [31:0]      dat_q;
    logic [31:0]      rdata;
    logic [31:0]      mask32;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] typ_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] in_v;
    logic [WIDTH-1:0] stat;
    logic             unused_ok;

    assign req    = bus.wb_cyc_i & bus.wb_stb_i & ~(ack_q | err_q);
    assign rsvd   = (bus.wb_adr_i == ADR_RSVD);
    assign wr     = req & bus.wb_we_i & ~rsvd;
    assign mask32 = sel_mask(bus.wb_sel_i);
    assign wmask  = mask32[WIDTH-1:0];
    assign wdat   = bus.wb_dat_i[WIDTH-1:0];
    assign clr    = (wr && bus.wb_adr_i == ADR_STAT) ? (wdat & wmask) : '0;

    assign unused_ok = ^{bus.wb_cti_i, bus.wb_bte_i, bus.wb_dat_i, mask32};

`ifdef GPIO_DEBOUNCE_EN
    logic [31:0] div_cnt;
    logic        tick;

    assign tick = (div_cnt == 32'(DEBOUNCE_DIV - 1));

    // free-running debounce sample divider
    always_ff @(posedge wb_clk) begin
        if (wb_rst)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 32'd1;
    end
`else
    localparam int unused_div = DEBOUNCE_DIV;
`endif

    // single-cycle ack/err response with data captured at request
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req & ~rsvd;
            err_q <= req & rsvd;
            dat_q <= (req & ~rsvd) ? rdata : '0;
        end
    end

    // control registers, byte-lane masked writes
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            out_q <= '0;
            dir_q <= '0;
            en_q  <= '0;
            typ_q <= '0;
            pol_q <= '0;
        end else if (wr) begin
            case (bus.wb_adr_i)
                ADR_OUT:  out_q <= (out_q & ~wmask) | (wdat & wmask);
                ADR_DIR:  dir_q <= (dir_q & ~wmask) | (wdat & wmask);
                ADR_EN:   en_q  <= (en_q  & ~wmask) | (wdat & wmask);
                ADR_TYPE: typ_q <= (typ_q & ~wmask) | (wdat & wmask);
                ADR_POL:  pol_q <= (pol_q & ~wmask) | (wdat & wmask);
                default: ;
            endcase
        end
    end

    // read mux, bits above WIDTH stay zero
    always_comb begin
        rdata = '0;
        case (bus.wb_adr_i)
            ADR_IN:   rdata[WIDTH-1:0] = in_v;
            ADR_OUT:  rdata[WIDTH-1:0] = out_q;
            ADR_DIR:  rdata[WIDTH-1:0] = dir_q;
            ADR_EN:   rdata[WIDTH-1:0] = en_q;
            ADR_TYPE: rdata[WIDTH-1:0] = typ_q;
            ADR_POL:  rdata[WIDTH-1:0] = pol_q;
            ADR_STAT: rdata[WIDTH-1:0] = stat;
            default: ;
        endcase
    end

    // aggregated interrupt, registered toward the core
    always_ff @(posedge wb_clk) begin
        if (wb_rst) irq_q <= 1'b0;
        else        irq_q <= |(stat & en_q);
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        gpio_irq_bit #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk    (wb_clk),
            .rst    (wb_rst),
`ifdef GPIO_DEBOUNCE_EN
            .tick   (tick),
`endif
            .pad    (gpio_i[g]),
            .en     (en_q[g]),
            .typ    (typ_q[g]),
            .pol    (pol_q[g]),
            .clr    (clr[g]),
            .in_o   (in_v[g]),
            .stat_o (stat[g])
        );
    end

    assign bus.wb_dat_o = dat_q;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_rty_o = 1'b0;
    assign gpio_o       = out_q;
    assign gpio_dir_o   = dir_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: directed register/interrupt
// scenarios followed by random traffic against a behavioural model.
module tb_wb_gpio_irq;
    import wb_gpio_irq_pkg::*;

    localparam int W   = 8;
    localparam int SS  = 2;
    localparam int DIV = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int SETTLE = 3*DIV + SS + 6;
`else
    localparam int SETTLE = SS + 2;
`endif

    logic         wb_clk = 1'b0;
    logic         wb_rst = 1'b1;
    logic [W-1:0] gpio_i = '0;
    logic [W-1:0] gpio_o;
    logic [W-1:0] gpio_dir_o;
    logic         irq_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_out, m_dir, m_en, m_typ, m_pol, m_stat, m_pad;

    wb_gpio_irq_if bus ();

    wb_gpio_irq #(
        .WIDTH        (W),
        .SYNC_STAGES  (SS),
        .DEBOUNCE_DIV (DIV)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .bus        (bus),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_dir_o (gpio_dir_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    task automatic xfer(input logic we, input logic [2:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd);
        int waits;
        logic ack, err;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        waits = 0;
        do begin
            cyc(1);
            waits++;
        end while (!(bus.wb_ack_o || bus.wb_err_o) && waits < 16);
        ack = bus.wb_ack_o;
        err = bus.wb_err_o;
        rd  = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        check("latency", waits, 1);
        check("ack", ack, adr != ADR_RSVD);
        check("err", err, adr == ADR_RSVD);
        cyc(1);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
        logic [31:0] rd;
        xfer(1'b1, adr, dat, sel, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] adr,
                          input logic [31:0] exp);
        logic [31:0] rd;
        xfer(1'b0, adr, 32'h0, 4'hf, rd);
        check(tag, rd, exp);
    endtask

    function automatic void m_level();
        m_stat |= m_en & ~m_typ & ~(m_pad ^ m_pol);
    endfunction

    function automatic void m_set_pad(input logic [7:0] nv);
        logic [7:0] rise, fall;
        rise = nv & ~m_pad;
        fall = ~nv & m_pad;
        m_stat |= m_en & m_typ & ((m_pol & rise) | (~m_pol & fall));
        m_pad = nv;
        m_level();
    endfunction

    function automatic void m_write(input logic [2:0] adr,
                                    input logic [31:0] dat,
                                    input logic [3:0] sel);
        logic [7:0] mk, d;
        mk = {8{sel[0]}};
        d  = dat[7:0];
        case (adr)
            ADR_OUT:  m_out = (m_out & ~mk) | (d & mk);
            ADR_DIR:  m_dir = (m_dir & ~mk) | (d & mk);
            ADR_EN:   m_en  = (m_en  & ~mk) | (d & mk);
            ADR_TYPE: m_typ = (m_typ & ~mk) | (d & mk);
            ADR_POL:  m_pol = (m_pol & ~mk) | (d & mk);
            ADR_STAT: m_stat &= ~(d & mk);
            default: ;
        endcase
        m_level();
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] adr);
        case (adr)
            ADR_IN:   return {24'h0, m_pad};
            ADR_OUT:  return {24'h0, m_out};
            ADR_DIR:  return {24'h0, m_dir};
            ADR_EN:   return {24'h0, m_en};
            ADR_TYPE: return {24'h0, m_typ};
            ADR_POL:  return {24'h0, m_pol};
            ADR_STAT: return {24'h0, m_stat};
            default:  return 32'h0;
        endcase
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cti_i = CTI_CLASSIC;
        bus.wb_bte_i = 2'b00;

        cyc(3);
        wb_rst = 1'b0;
        cyc(1);

        check("rst_gpio_o", gpio_o, 0);
        check("rst_dir", gpio_dir_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_ack", bus.wb_ack_o, 0);
        check("rty", bus.wb_rty_o, 0);
        for (int i = 0; i < 8; i++) rd_chk("rst_rd", 3'(i), 0);

        wr(ADR_OUT, 32'h0000_00a5, 4'b0001);
        wr(ADR_OUT, 32'h0000_ffff, 4'b0010);
        check("out_lanes", gpio_o, 8'ha5);
        wr(ADR_DIR, 32'h0000_000f, 4'hf);
        check("dir", gpio_dir_o, 8'h0f);
        rd_chk("rd_out", ADR_OUT, 32'ha5);

        gpio_i = 8'h3c;
`ifndef GPIO_DEBOUNCE_EN
        rd_chk("in_early", ADR_IN, 0);
`endif
        cyc(SETTLE);
        rd_chk("in_3c", ADR_IN, 32'h3c);

        gpio_i = 8'h00;
        cyc(SETTLE);
        wr(ADR_EN, 1, 4'hf);
        wr(ADR_TYPE, 1, 4'hf);
        wr(ADR_POL, 1, 4'hf);
        gpio_i = 8'h01;
        cyc(SETTLE);
        rd_chk("edge_stat", ADR_STAT, 1);
        check("edge_irq", irq_o, 1);
        wr(ADR_STAT, 1, 4'hf);
        check("clr_irq", irq_o, 0);
        rd_chk("clr_stat", ADR_STAT, 0);

`ifndef GPIO_DEBOUNCE_EN
        gpio_i = 8'h00;
        cyc(SETTLE);
        gpio_i = 8'h01;
        cyc(SS);
        wr(ADR_STAT, 1, 4'hf);
        rd_chk("set_wins", ADR_STAT, 1);
`endif

        wr(ADR_EN, 0, 4'hf);
        wr(ADR_STAT, 32'hff, 4'hf);
        gpio_i = 8'h00;
        cyc(SETTLE);
        wr(ADR_TYPE, 0, 4'hf);
        wr(ADR_POL, 0, 4'hf);
        wr(ADR_EN, 8, 4'hf);
        rd_chk("lvl_set", ADR_STAT, 8);
        wr(ADR_STAT, 8, 4'hf);
        rd_chk("lvl_sticky", ADR_STAT, 8);
        gpio_i = 8'h08;
        cyc(SETTLE);
        wr(ADR_STAT, 8, 4'hf);
        rd_chk("lvl_clr", ADR_STAT, 0);
        wr(ADR_EN, 0, 4'hf);
        wr(ADR_EN, 8, 4'hf);
        rd_chk("en_toggle", ADR_STAT, 0);
        cyc(2);
        check("lvl_irq", irq_o, 0);

`ifdef GPIO_DEBOUNCE_EN
        wr(ADR_EN, 0, 4'hf);
        gpio_i = 8'h00;
        cyc(SETTLE);
        gpio_i = 8'h02;
        cyc(DIV);
        gpio_i = 8'h00;
        cyc(SETTLE);
        rd_chk("glitch", ADR_IN, 0);
        gpio_i = 8'h02;
        cyc(SS + 2*DIV + 1);
        rd_chk("deb_in", ADR_IN, 2);
`endif

        gpio_i = 8'h00;
        cyc(SETTLE);
        bus.wb_adr_i = ADR_OUT;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        cyc(1);
        wb_rst = 1'b1;
        cyc(1);
        check("mid_rst_ack", bus.wb_ack_o, 0);
        check("mid_rst_out", gpio_o, 0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        cyc(1);
        wb_rst = 1'b0;
        cyc(1);

        m_out = 0; m_dir = 0; m_en = 0; m_typ = 0;
        m_pol = 0; m_stat = 0; m_pad = 0;

        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    d = $urandom;
                    gpio_i = d[7:0];
                    cyc(SETTLE);
                    m_set_pad(d[7:0]);
                end
                1, 3: begin
                    a = 3'($urandom_range(0, 7));
                    d = $urandom;
                    s = 4'($urandom_range(0, 15));
                    wr(a, d, s);
                    m_write(a, d, s);
                end
                default: begin
                    a = 3'($urandom_range(0, 7));
                    rd_chk("rnd_rd", a, m_read(a));
                end
            endcase
            cyc(2);
            check("rnd_irq", irq_o, |(m_stat & m_en));
            check("rnd_out", gpio_o, m_out);
            check("rnd_dir", gpio_dir_o, m_dir);
        end
        for (int i = 0; i < 8; i++) rd_chk("final_rd", 3'(i), m_read(3'(i)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
